// File: rtl/shared_mem_writer_pkg.sv
// Shared multiprocessor package for the shared-memory writer.
// Holds the memory geometry defaults, the round-robin pointer encoding and
// the address helpers used by both the top level and the pending slots.
package shared_mem_writer_pkg;

  localparam int SMW_DEPTH    = 200;  // 8-bit words in the shared memory
  localparam int SMW_B_OFFSET = 100;  // physical base of every port-B address

  // Round-robin pointer: which port committed most recently.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  // Logical 8-bit address plus port base, computed 9 bits wide so the
  // result can never wrap back into range.
  function automatic logic [8:0] phys_addr(input logic [7:0] addr, input logic [8:0] base);
    return {1'b0, addr} + base;
  endfunction

  function automatic logic in_range(input logic [8:0] addr, input int depth);
    return int'({23'b0, addr}) < depth;
  endfunction

endpackage

// File: rtl/shared_mem_writer_if.sv
// Bus bundle of the shared-memory writer: two write ports (A and B), two
// synchronous read ports, the sticky-flag clear, write acks and sticky
// overflow / range-error flags.
//   master : the agent driving requests (processors / testbench)
//   slave  : the shared_mem_writer itself
interface shared_mem_writer_if;
  logic [7:0] addr_a;
  logic [7:0] wdata_a;
  logic       wr_a;
  logic [7:0] addr_b;
  logic [7:0] wdata_b;
  logic       wr_b;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic       clr_err;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       ack_a;
  logic       ack_b;
  logic       ovf_a;
  logic       ovf_b;
  logic       err_a;
  logic       err_b;

  modport master (
    output addr_a, wdata_a, wr_a, addr_b, wdata_b, wr_b, rd_addr_a, rd_addr_b, clr_err,
    input  rd_data_a, rd_data_b, ack_a, ack_b, ovf_a, ovf_b, err_a, err_b
  );

  modport slave (
    input  addr_a, wdata_a, wr_a, addr_b, wdata_b, wr_b, rd_addr_a, rd_addr_b, clr_err,
    output rd_data_a, rd_data_b, ack_a, ack_b, ovf_a, ovf_b, err_a, err_b
  );
endinterface

// File: rtl/shared_mem_writer_wr_slot.sv
// One-entry pending write buffer for a single port.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   wr                   write strobe (one-cycle pulse)
//   phys_addr, wdata     physical address and data of the strobe
//   grant                arbiter commits this slot at the coming edge
//   valid, addr, data    current pending entry
//   err_set              strobe was out of range (discarded)
//   ovf_set              strobe hit an occupied, non-committing slot (discarded)
module wr_slot
  import shared_mem_writer_pkg::*;
#(
  parameter int DEPTH = SMW_DEPTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic [8:0] phys_addr,
  input  logic [7:0] wdata,
  input  logic       grant,
  output logic       valid,
  output logic [8:0] addr,
  output logic [7:0] data,
  output logic       err_set,
  output logic       ovf_set
);

  logic       valid_reg;
  logic [8:0] addr_reg;
  logic [7:0] data_reg;
  logic       in_rng;
  logic       accept;

  always_comb begin
    in_rng  = in_range(phys_addr, DEPTH);
    err_set = wr & ~in_rng;
    // A slot that commits this edge is free again, so it may take a new
    // request in the same cycle without losing throughput.
    accept  = wr & in_rng & (~valid_reg | grant);
    ovf_set = wr & in_rng & valid_reg & ~grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      addr_reg  <= phys_addr;
      data_reg  <= wdata;
    end else if (grant) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign addr  = addr_reg;
  assign data  = data_reg;

endmodule

// File: rtl/shared_mem_writer.sv
// Two-port shared-memory writer.
// Each port owns a one-entry pending slot; a round-robin arbiter commits at
// most one slot per cycle into a single-write-port memory. Both ports also
// have a registered (read-first) read path. Port B addresses are offset by
// B_OFFSET for writes and reads alike.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           shared_mem_writer_if.slave (requests, read data, acks, flags)
module shared_mem_writer
  import shared_mem_writer_pkg::*;
#(
  parameter int DEPTH    = SMW_DEPTH,
  parameter int B_OFFSET = SMW_B_OFFSET
) (
  input logic                clk,
  input logic                reset_n,
  shared_mem_writer_if.slave bus
);

  localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] B_OFF = 9'(B_OFFSET);

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0] wr;
  logic [1:0] grant;
  logic [1:0] valid;
  logic [1:0] slot_err;
  logic [1:0] slot_ovf;
  logic [1:0] rd_ok;
  logic [8:0] wr_phys   [2];
  logic [7:0] wr_data   [2];
  logic [8:0] slot_addr [2];
  logic [7:0] slot_data [2];
  logic [8:0] rd_phys   [2];

  logic       commit;
  logic [8:0] commit_addr;
  logic [7:0] commit_data;

  last_e      last_reg;
  last_e      last_next;

  logic [1:0] ack_reg;
  logic [1:0] ovf_reg;
  logic [1:0] err_reg;
  logic [7:0] rd_data_reg [2];

  // Contents are deliberately left out of reset.
  logic [7:0] mem [DEPTH];

  always_comb begin
    wr         = {bus.wr_b, bus.wr_a};
    wr_phys[0] = phys_addr(bus.addr_a, 9'd0);
    wr_phys[1] = phys_addr(bus.addr_b, B_OFF);
    wr_data[0] = bus.wdata_a;
    wr_data[1] = bus.wdata_b;
    rd_phys[0] = phys_addr(bus.rd_addr_a, 9'd0);
    rd_phys[1] = phys_addr(bus.rd_addr_b, B_OFF);
    rd_ok[0]   = in_range(rd_phys[0], DEPTH);
    rd_ok[1]   = in_range(rd_phys[1], DEPTH);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      wr_slot #(.DEPTH(DEPTH)) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr        (wr[gi]),
        .phys_addr (wr_phys[gi]),
        .wdata     (wr_data[gi]),
        .grant     (grant[gi]),
        .valid     (valid[gi]),
        .addr      (slot_addr[gi]),
        .data      (slot_data[gi]),
        .err_set   (slot_err[gi]),
        .ovf_set   (slot_ovf[gi])
      );
    end
  endgenerate

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_reg <= LAST_B;
    end else begin
      last_reg <= last_next;
    end
  end

  // Grant: on contention the port that did not commit last wins.
  always_comb begin
    grant       = 2'b00;
    last_next   = last_reg;
    if (valid[0] && (!valid[1] || last_reg == LAST_B)) begin
      grant[0]  = 1'b1;
      last_next = LAST_A;
    end else if (valid[1]) begin
      grant[1]  = 1'b1;
      last_next = LAST_B;
    end
    commit      = |grant;
    commit_addr = grant[1] ? slot_addr[1] : slot_addr[0];
    commit_data = grant[1] ? slot_data[1] : slot_data[0];
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[AW'(commit_addr)] <= commit_data;
    end
  end

  // Read data, acks and sticky flags. The read samples the array before the
  // same-edge commit lands, giving read-first behaviour. Set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_reg        <= 2'b00;
      ovf_reg        <= 2'b00;
      err_reg        <= 2'b00;
      rd_data_reg[0] <= 8'h00;
      rd_data_reg[1] <= 8'h00;
    end else begin
      ack_reg <= grant;
      ovf_reg <= slot_ovf | (ovf_reg & ~{2{bus.clr_err}});
      err_reg <= slot_err | ~rd_ok | (err_reg & ~{2{bus.clr_err}});
      for (int i = 0; i < 2; i++) begin
        rd_data_reg[i] <= rd_ok[i] ? mem[AW'(rd_phys[i])] : 8'h00;
      end
    end
  end

  assign bus.ack_a     = ack_reg[0];
  assign bus.ack_b     = ack_reg[1];
  assign bus.ovf_a     = ovf_reg[0];
  assign bus.ovf_b     = ovf_reg[1];
  assign bus.err_a     = err_reg[0];
  assign bus.err_b     = err_reg[1];
  assign bus.rd_data_a = rd_data_reg[0];
  assign bus.rd_data_b = rd_data_reg[1];

endmodule

// File: tb/tb_shared_mem_writer.sv
module tb_shared_mem_writer;
  import shared_mem_writer_pkg::*;

  localparam int DEPTH    = SMW_DEPTH;
  localparam int B_OFFSET = SMW_B_OFFSET;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  shared_mem_writer_if bus ();

  shared_mem_writer #(.DEPTH(DEPTH), .B_OFFSET(B_OFFSET)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct { int tag; int addr; int data; } ack_t;
  typedef struct { int tag; logic [7:0] data; } rd_t;
  typedef struct { int tag; logic [3:0] flags; } flag_t;  // {ovf_b, ovf_a, err_b, err_a}

  ack_t  ack_q_a[$];
  ack_t  ack_q_b[$];
  rd_t   rd_q_a[$];
  rd_t   rd_q_b[$];
  flag_t flag_q[$];

  int edge_n   = 0;
  int checks   = 0;
  int failures = 0;

  // Reference model: memory word map, per-port pending request, last winner.
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  bit         m_pv    [2];
  int         m_pa    [2];
  int         m_pd    [2];
  int         m_last;            // 0: A committed last, 1: B committed last
  bit         m_ovf   [2];
  bit         m_err   [2];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic void model_reset();
    m_pv[0] = 0; m_pv[1] = 0;
    m_last  = 1;
    m_ovf[0] = 0; m_ovf[1] = 0; m_err[0] = 0; m_err[1] = 0;
    ack_q_a.delete(); ack_q_b.delete();
    rd_q_a.delete();  rd_q_b.delete();
    flag_q.delete();
  endfunction

  // Predict everything the coming clock edge produces from the current inputs.
  function automatic void model_edge();
    int   tag = edge_n + 1;
    int   g;
    bit   wr [2];
    int   wphys [2];
    int   wdat [2];
    int   rphys [2];
    bit   s_ovf [2];
    bit   s_err [2];
    bit   clr = bus.clr_err;
    rd_t  r;
    ack_t a;
    flag_t f;
    wr[0] = bus.wr_a; wphys[0] = int'(bus.addr_a);            wdat[0] = int'(bus.wdata_a);
    wr[1] = bus.wr_b; wphys[1] = int'(bus.addr_b) + B_OFFSET; wdat[1] = int'(bus.wdata_b);
    rphys[0] = int'(bus.rd_addr_a);
    rphys[1] = int'(bus.rd_addr_b) + B_OFFSET;
    s_ovf[0] = 0; s_ovf[1] = 0; s_err[0] = 0; s_err[1] = 0;

    // reads see memory as it was before this edge's write
    for (int p = 0; p < 2; p++) begin
      r.tag = tag;
      if (rphys[p] >= DEPTH) begin
        s_err[p] = 1;
        r.data = 8'h00;
        if (p == 0) rd_q_a.push_back(r); else rd_q_b.push_back(r);
      end else if (m_known[rphys[p]]) begin
        r.data = m_mem[rphys[p]];
        if (p == 0) rd_q_a.push_back(r); else rd_q_b.push_back(r);
      end
    end

    // one commit per cycle; on contention the port that did not go last
    g = -1;
    if (m_pv[0] && m_pv[1]) g = (m_last == 1) ? 0 : 1;
    else if (m_pv[0])       g = 0;
    else if (m_pv[1])       g = 1;
    if (g >= 0) begin
      m_mem[m_pa[g]]   = 8'(m_pd[g]);
      m_known[m_pa[g]] = 1;
      m_pv[g]  = 0;
      m_last   = g;
      a.tag = tag; a.addr = m_pa[g]; a.data = m_pd[g];
      if (g == 0) ack_q_a.push_back(a); else ack_q_b.push_back(a);
    end

    // new requests
    for (int p = 0; p < 2; p++) begin
      if (wr[p]) begin
        if (wphys[p] >= DEPTH) s_err[p] = 1;
        else if (m_pv[p])      s_ovf[p] = 1;
        else begin
          m_pv[p] = 1; m_pa[p] = wphys[p]; m_pd[p] = wdat[p];
        end
      end
    end

    for (int p = 0; p < 2; p++) begin
      m_ovf[p] = s_ovf[p] | (m_ovf[p] & !clr);
      m_err[p] = s_err[p] | (m_err[p] & !clr);
    end
    f.tag = tag;
    f.flags = {m_ovf[1], m_ovf[0], m_err[1], m_err[0]};
    flag_q.push_back(f);
  endfunction

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge clk) begin : monitor
    ack_t  a;
    rd_t   r;
    flag_t f;
    if (!reset_n) begin
      chk("outputs_in_reset",
          {10'd0, bus.ack_a, bus.ack_b, bus.ovf_a, bus.ovf_b, bus.err_a, bus.err_b,
           bus.rd_data_a, bus.rd_data_b}, 32'd0);
    end else begin
      if (bus.ack_a) begin
        if (ack_q_a.size() == 0) chk("ack_a_unexpected", 1, 0);
        else begin
          a = ack_q_a.pop_front();
          chk("ack_a_cycle", edge_n, a.tag);
          $display("ack_a cycle=%0d addr=%0d data=%02h", edge_n, a.addr, a.data);
        end
      end
      if (ack_q_a.size() > 0 && ack_q_a[0].tag < edge_n) begin
        a = ack_q_a.pop_front();
        chk("ack_a_missing_cycle", edge_n, a.tag);
      end
      if (bus.ack_b) begin
        if (ack_q_b.size() == 0) chk("ack_b_unexpected", 1, 0);
        else begin
          a = ack_q_b.pop_front();
          chk("ack_b_cycle", edge_n, a.tag);
          $display("ack_b cycle=%0d addr=%0d data=%02h", edge_n, a.addr, a.data);
        end
      end
      if (ack_q_b.size() > 0 && ack_q_b[0].tag < edge_n) begin
        a = ack_q_b.pop_front();
        chk("ack_b_missing_cycle", edge_n, a.tag);
      end
      if (rd_q_a.size() > 0 && rd_q_a[0].tag <= edge_n) begin
        r = rd_q_a.pop_front();
        chk("rd_data_a", {24'd0, bus.rd_data_a}, {24'd0, r.data});
      end
      if (rd_q_b.size() > 0 && rd_q_b[0].tag <= edge_n) begin
        r = rd_q_b.pop_front();
        chk("rd_data_b", {24'd0, bus.rd_data_b}, {24'd0, r.data});
      end
      if (flag_q.size() > 0 && flag_q[0].tag <= edge_n) begin
        f = flag_q.pop_front();
        chk("flags_ovfb_ovfa_errb_erra",
            {28'd0, bus.ovf_b, bus.ovf_a, bus.err_b, bus.err_a}, {28'd0, f.flags});
      end
    end
  end

  task automatic tick();
    model_edge();
    @(posedge clk);
    edge_n++;
    #1;
    bus.wr_a = 1'b0;
    bus.wr_b = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic do_reset(input int n);
    bus.wr_a = 1'b0; bus.wr_b = 1'b0; bus.clr_err = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("reset_outputs_zero",
        {10'd0, bus.ack_a, bus.ack_b, bus.ovf_a, bus.ovf_b, bus.err_a, bus.err_b,
         bus.rd_data_a, bus.rd_data_b}, 32'd0);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      #1;
    end
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_a_addr();
    int r = $urandom_range(0, 99);
    if (r < 4)  return 8'(200 + $urandom_range(0, 55));
    if (r < 52) return 8'($urandom_range(0, 15));
    return 8'(100 + $urandom_range(0, 15));
  endfunction

  function automatic logic [7:0] rand_b_addr();
    if ($urandom_range(0, 99) < 4) return 8'(100 + $urandom_range(0, 155));
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    bus.addr_a = 0; bus.wdata_a = 0; bus.wr_a = 0;
    bus.addr_b = 0; bus.wdata_b = 0; bus.wr_b = 0;
    bus.rd_addr_a = 0; bus.rd_addr_b = 0; bus.clr_err = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    model_reset();
    #2;
    do_reset(3);

    // Tie after reset: A first, then B; back-to-back B strobe overflows.
    bus.addr_a = 20; bus.wdata_a = 8'h11; bus.wr_a = 1;
    bus.addr_b = 30; bus.wdata_b = 8'h22; bus.wr_b = 1;
    tick();
    bus.addr_a = 21; bus.wdata_a = 8'h12; bus.wr_a = 1;
    bus.addr_b = 31; bus.wdata_b = 8'h33; bus.wr_b = 1;
    tick();
    chk("tie_ack_a_first", {bus.ack_b, bus.ack_a}, 2'b01);
    chk("ovf_b_set", bus.ovf_b, 1);
    tick();
    chk("tie_ack_b_next", {bus.ack_b, bus.ack_a}, 2'b10);
    tick();
    chk("stream_ack_a", {bus.ack_b, bus.ack_a}, 2'b01);
    // Repeated tie: A went last, so B wins.
    bus.addr_a = 22; bus.wdata_a = 8'h44; bus.wr_a = 1;
    bus.addr_b = 32; bus.wdata_b = 8'h55; bus.wr_b = 1;
    tick();
    tick();
    chk("retie_ack_b_first", {bus.ack_b, bus.ack_a}, 2'b10);
    bus.rd_addr_b = 30;
    tick();
    chk("retie_ack_a_next", {bus.ack_b, bus.ack_a}, 2'b01);
    chk("ovf_first_data_kept", bus.rd_data_b, 8'h22);
    bus.clr_err = 1;
    tick();

    // Port-A write and read back.
    bus.addr_a = 5; bus.wdata_a = 8'hAA; bus.wr_a = 1;
    tick();
    tick();
    chk("ack_a_after_write", bus.ack_a, 1);
    bus.rd_addr_a = 5;
    tick();
    chk("rd_a_addr5", bus.rd_data_a, 8'hAA);

    // Port-B offset.
    bus.addr_b = 10; bus.wdata_b = 8'h3C; bus.wr_b = 1;
    tick();
    tick();
    chk("ack_b_after_write", bus.ack_b, 1);
    bus.rd_addr_a = 110; bus.rd_addr_b = 10;
    tick();
    chk("rd_a_phys110", bus.rd_data_a, 8'h3C);
    chk("rd_b_logical10", bus.rd_data_b, 8'h3C);

    // Port-B range error, then clear.
    bus.addr_b = 100; bus.wdata_b = 8'h5A; bus.wr_b = 1;
    tick();
    chk("err_b_set", bus.err_b, 1);
    tick();
    chk("no_ack_b_on_err", bus.ack_b, 0);
    bus.clr_err = 1;
    tick();
    chk("err_b_cleared", bus.err_b, 0);

    // Reset with a pending write: word keeps its old value.
    bus.addr_a = 50; bus.wdata_a = 8'h77; bus.wr_a = 1;
    tick();
    tick();
    bus.addr_a = 50; bus.wdata_a = 8'h99; bus.wr_a = 1;
    tick();
    do_reset(2);
    bus.rd_addr_a = 50;
    tick();
    chk("no_ack_a_after_reset", bus.ack_a, 0);
    chk("word_kept_after_reset", bus.rd_data_a, 8'h77);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset(2);
      bus.wr_a      = ($urandom_range(0, 99) < 45);
      bus.addr_a    = rand_a_addr();
      bus.wdata_a   = 8'($urandom);
      bus.wr_b      = ($urandom_range(0, 99) < 45);
      bus.addr_b    = rand_b_addr();
      bus.wdata_b   = 8'($urandom);
      bus.rd_addr_a = ($urandom_range(0, 99) < 3) ? 8'(200 + $urandom_range(0, 55)) : rand_a_addr();
      if (bus.rd_addr_a >= 200 && $urandom_range(0, 1) == 0) bus.rd_addr_a = 8'($urandom_range(0, 15));
      bus.rd_addr_b = ($urandom_range(0, 99) < 3) ? 8'(100 + $urandom_range(0, 155))
                                                  : 8'($urandom_range(0, 15));
      bus.clr_err   = ($urandom_range(0, 99) < 8);
      tick();
    end

    bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    repeat (4) tick();
    chk("ack_queues_drained", ack_q_a.size() + ack_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
